// File: rtl/arm_control_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the ARM-subset datapath (LEs, mux selects, ALU op, memory request).
// Latency: 4 cycles F0->F0 for a failed condition, more for DP/load/store/branch; memory states add one cycle per MOC=0.
// Backpressure: MOV is held until MOC; after MEM_WAIT_MAX idle cycles the access is abandoned and MEM_ERR pulses.
module arm_control_sequencer #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [31:0] IR,
  input  logic        COND_OK,
  input  logic        MOC,
  output logic        IR_LE,
  output logic        MAR_LE,
  output logic        MDR_LE,
  output logic        SR_LE,
  output logic        RF_LE,
  output logic        PC_LE,
  output logic [1:0]  MA_SEL,
  output logic [1:0]  MB_SEL,
  output logic        MDR_SEL,
  output logic        RD_SEL,
  output logic [3:0]  ALU_OP,
  output logic        MOV,
  output logic        MEM_RW,
  output logic        MEM_ERR,
  output logic [3:0]  STATE
);

  localparam logic [3:0] S_RST  = 4'd0;
  localparam logic [3:0] S_F0   = 4'd1;
  localparam logic [3:0] S_F1   = 4'd2;
  localparam logic [3:0] S_F2   = 4'd3;
  localparam logic [3:0] S_DEC  = 4'd4;
  localparam logic [3:0] S_DP   = 4'd5;
  localparam logic [3:0] S_LSA  = 4'd6;
  localparam logic [3:0] S_LDW  = 4'd7;
  localparam logic [3:0] S_LDWB = 4'd8;
  localparam logic [3:0] S_STM  = 4'd9;
  localparam logic [3:0] S_STW  = 4'd10;
  localparam logic [3:0] S_BR   = 4'd11;
  localparam logic [3:0] S_BL   = 4'd12;

  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;

  // Last idle cycle allowed: a miss here means MEM_WAIT_MAX cycles have gone by without MOC.
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT_MAX - 1);

  logic [3:0] state;
  logic [3:0] next_state;
  logic [3:0] wait_cnt;
  logic       mem_err_q;
  logic       mem_state;
  logic       timeout;
  logic       compare_op;
  logic       unused_ir;

  assign unused_ir  = ^{IR[31:28], IR[19:0]};
  assign mem_state  = (state == S_F2) || (state == S_LDW) || (state == S_STW);
  assign timeout    = mem_state && !MOC && (wait_cnt == WAIT_LAST);
  assign compare_op = (IR[24:23] == 2'b10);

  // Next-state selection; completion (MOC) takes priority over timeout.
  always_comb begin
    next_state = S_RST;
    case (state)
      S_RST:  next_state = S_F0;
      S_F0:   next_state = S_F1;
      S_F1:   next_state = S_F2;
      S_F2:   next_state = MOC ? S_DEC : (timeout ? S_F0 : S_F2);
      S_DEC: begin
        if (!COND_OK) next_state = S_F0;
        else begin
          case (IR[27:25])
            3'b000, 3'b001: next_state = S_DP;
            3'b010, 3'b011: next_state = S_LSA;
            3'b101:         next_state = S_BR;
            default:        next_state = S_F0;
          endcase
        end
      end
      S_DP:   next_state = S_F0;
      S_LSA:  next_state = IR[20] ? S_LDW : S_STM;
      S_LDW:  next_state = MOC ? S_LDWB : (timeout ? S_F0 : S_LDW);
      S_LDWB: next_state = S_F0;
      S_STM:  next_state = S_STW;
      S_STW:  next_state = (MOC || timeout) ? S_F0 : S_STW;
      S_BR:   next_state = IR[24] ? S_BL : S_F0;
      S_BL:   next_state = S_F0;
      default: next_state = S_RST;
    endcase
  end

  // State register with asynchronous clear.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) state <= S_RST;
    else      state <= next_state;
  end

  // Idle-cycle counter: restarts on every state change, counts MOC=0 cycles inside memory states.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR)                        wait_cnt <= 4'd0;
    else if (next_state != state)    wait_cnt <= 4'd0;
    else if (mem_state && !MOC)      wait_cnt <= wait_cnt + 4'd1;
  end

  // Error pulse is registered so it appears for exactly the one cycle after the abandoned access.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) mem_err_q <= 1'b0;
    else      mem_err_q <= timeout;
  end

  // Output decode from state and IR; the IR/MDR load strobes are qualified by MOC so they fire only on completion.
  always_comb begin
    IR_LE   = 1'b0;
    MAR_LE  = 1'b0;
    MDR_LE  = 1'b0;
    SR_LE   = 1'b0;
    RF_LE   = 1'b0;
    PC_LE   = 1'b0;
    MA_SEL  = 2'd0;
    MB_SEL  = 2'd0;
    MDR_SEL = 1'b0;
    RD_SEL  = 1'b0;
    ALU_OP  = 4'd0;
    MOV     = 1'b0;
    MEM_RW  = 1'b0;
    MEM_ERR = mem_err_q;
    STATE   = state;
    case (state)
      S_F0: begin
        MA_SEL = 2'd1; MB_SEL = 2'd3; ALU_OP = ALU_ADD; MAR_LE = 1'b1;
      end
      S_F1: begin
        MA_SEL = 2'd1; MB_SEL = 2'd1; ALU_OP = ALU_ADD; PC_LE = 1'b1;
        MOV = 1'b1; MEM_RW = 1'b1;
      end
      S_F2: begin
        MOV = 1'b1; MEM_RW = 1'b1; IR_LE = MOC;
      end
      S_DP: begin
        ALU_OP = IR[24:21];
        RF_LE  = !compare_op;
        SR_LE  = IR[20] | compare_op;
      end
      S_LSA: begin
        ALU_OP = IR[23] ? ALU_ADD : ALU_SUB; MAR_LE = 1'b1;
      end
      S_LDW: begin
        MOV = 1'b1; MEM_RW = 1'b1; MDR_SEL = 1'b1; MDR_LE = MOC;
      end
      S_LDWB: begin
        MA_SEL = 2'd2; MB_SEL = 2'd3; ALU_OP = ALU_ADD; RF_LE = 1'b1;
      end
      S_STM: begin
        MA_SEL = 2'd3; MB_SEL = 2'd2; ALU_OP = ALU_ADD; MDR_LE = 1'b1;
      end
      S_STW: begin
        MOV = 1'b1;
      end
      S_BR: begin
        MA_SEL = 2'd1; ALU_OP = ALU_ADD;
        if (IR[24]) begin
          RD_SEL = 1'b1; MB_SEL = 2'd3; RF_LE = 1'b1;
        end else begin
          MB_SEL = 2'd0; PC_LE = 1'b1;
        end
      end
      S_BL: begin
        MA_SEL = 2'd1; MB_SEL = 2'd0; ALU_OP = ALU_ADD; PC_LE = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_arm_control_sequencer.sv
// Self-checking bench for arm_control_sequencer: directed instructions then random ones,
// each expanded into a per-cycle list of expected control outputs by a phase-level model.
// Every cycle the whole output vector is compared against the model.
module tb_arm_control_sequencer;

  logic        CLK = 1'b0;
  logic        CLR;
  logic [31:0] IR;
  logic        COND_OK;
  logic        MOC;
  logic        IR_LE, MAR_LE, MDR_LE, SR_LE, RF_LE, PC_LE;
  logic [1:0]  MA_SEL, MB_SEL;
  logic        MDR_SEL, RD_SEL;
  logic [3:0]  ALU_OP;
  logic        MOV, MEM_RW, MEM_ERR;
  logic [3:0]  STATE;

  arm_control_sequencer #(.MEM_WAIT_MAX(15)) dut (
    .CLK(CLK), .CLR(CLR), .IR(IR), .COND_OK(COND_OK), .MOC(MOC),
    .IR_LE(IR_LE), .MAR_LE(MAR_LE), .MDR_LE(MDR_LE), .SR_LE(SR_LE),
    .RF_LE(RF_LE), .PC_LE(PC_LE), .MA_SEL(MA_SEL), .MB_SEL(MB_SEL),
    .MDR_SEL(MDR_SEL), .RD_SEL(RD_SEL), .ALU_OP(ALU_OP), .MOV(MOV),
    .MEM_RW(MEM_RW), .MEM_ERR(MEM_ERR), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  localparam int          WAIT_MAX = 15;
  localparam logic [3:0]  ADD = 4'b0100;
  localparam logic [3:0]  SUB = 4'b0010;

  logic [22:0] obs;
  assign obs = {STATE, IR_LE, MAR_LE, MDR_LE, SR_LE, RF_LE, PC_LE, MA_SEL, MB_SEL,
                MDR_SEL, RD_SEL, ALU_OP, MOV, MEM_RW, MEM_ERR};

  typedef struct {
    logic [31:0] ir;
    logic        cond;
    logic        moc;
    logic [22:0] exp;
  } rec_t;

  rec_t        q[$];
  logic [31:0] cur_ir;
  logic        cur_cond;
  logic        pend_err;
  int          n_assert;
  int          n_fail;

  function automatic logic [22:0] ov(
    input logic [3:0] st, input logic ir_le, input logic mar_le, input logic mdr_le,
    input logic sr_le, input logic rf_le, input logic pc_le, input logic [1:0] ma,
    input logic [1:0] mb, input logic mdr_sel, input logic rd_sel, input logic [3:0] alu,
    input logic mov, input logic rw, input logic err);
    return {st, ir_le, mar_le, mdr_le, sr_le, rf_le, pc_le, ma, mb, mdr_sel, rd_sel, alu, mov, rw, err};
  endfunction

  function automatic void push(input logic moc, input logic [22:0] exp);
    rec_t r;
    r.ir = cur_ir; r.cond = cur_cond; r.moc = moc; r.exp = exp;
    q.push_back(r);
  endfunction

  // Non-memory cycle: MOC must be ignored, so drive it randomly.
  function automatic void push_rand(input logic [22:0] exp);
    push(1'($urandom_range(0, 1)), exp);
  endfunction

  // Memory access taking d idle cycles before MOC; returns 0 if it is abandoned.
  function automatic bit mem_phase(input logic [3:0] st, input int d, input logic rw);
    logic is_fetch, is_load;
    is_fetch = (st == 4'd3);
    is_load  = (st == 4'd7);
    for (int k = 0; k < WAIT_MAX; k++) begin
      if (k < d) begin
        push(1'b0, ov(st, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, is_load, 0, 4'd0, 1, rw, 0));
      end else begin
        push(1'b1, ov(st, is_fetch, 0, is_load, 0, 0, 0, 2'd0, 2'd0, is_load, 0, 4'd0, 1, rw, 0));
        return 1'b1;
      end
    end
    pend_err = 1'b1;
    return 1'b0;
  endfunction

  // Expand one instruction into its expected cycle sequence.
  function automatic void instr(input logic [31:0] ir, input logic cond, input int fd, input int dd);
    logic [2:0] cls;
    logic       cmp;
    cur_ir = ir; cur_cond = cond;
    push_rand(ov(4'd1, 0, 1, 0, 0, 0, 0, 2'd1, 2'd3, 0, 0, ADD, 0, 0, pend_err));
    pend_err = 1'b0;
    push_rand(ov(4'd2, 0, 0, 0, 0, 0, 1, 2'd1, 2'd1, 0, 0, ADD, 1, 1, 0));
    if (!mem_phase(4'd3, fd, 1'b1)) return;
    push_rand(ov(4'd4, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 4'd0, 0, 0, 0));
    if (!cond) return;
    cls = ir[27:25];
    cmp = (ir[24:23] == 2'b10);
    if (cls == 3'd0 || cls == 3'd1) begin
      push_rand(ov(4'd5, 0, 0, 0, ir[20] | cmp, !cmp, 0, 2'd0, 2'd0, 0, 0, ir[24:21], 0, 0, 0));
    end else if (cls == 3'd2 || cls == 3'd3) begin
      push_rand(ov(4'd6, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, ir[23] ? ADD : SUB, 0, 0, 0));
      if (ir[20]) begin
        if (!mem_phase(4'd7, dd, 1'b1)) return;
        push_rand(ov(4'd8, 0, 0, 0, 0, 1, 0, 2'd2, 2'd3, 0, 0, ADD, 0, 0, 0));
      end else begin
        push_rand(ov(4'd9, 0, 0, 1, 0, 0, 0, 2'd3, 2'd2, 0, 0, ADD, 0, 0, 0));
        void'(mem_phase(4'd10, dd, 1'b0));
      end
    end else if (cls == 3'd5) begin
      if (ir[24]) begin
        push_rand(ov(4'd11, 0, 0, 0, 0, 1, 0, 2'd1, 2'd3, 0, 1, ADD, 0, 0, 0));
        push_rand(ov(4'd12, 0, 0, 0, 0, 0, 1, 2'd1, 2'd0, 0, 0, ADD, 0, 0, 0));
      end else begin
        push_rand(ov(4'd11, 0, 0, 0, 0, 0, 1, 2'd1, 2'd0, 0, 0, ADD, 0, 0, 0));
      end
    end
  endfunction

  function automatic int pick_delay();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return WAIT_MAX;
    if (r == 1) return WAIT_MAX - 1;
    return $urandom_range(0, 3);
  endfunction

  initial begin
    rec_t r;
    int   idx;
    n_assert = 0; n_fail = 0; pend_err = 1'b0; idx = 0;
    cur_ir = '0; cur_cond = 1'b0;
    CLR = 1'b0; MOC = 1'b1; IR = 32'h0; COND_OK = 1'b0;

    // Reset held with MOC=1: everything idle.
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_assert++;
      assert (obs === 23'd0) else begin
        n_fail++;
        $error("FAIL reset%0d observed=%h expected=%h", i, obs, 23'd0);
      end
    end
    #2 CLR = 1'b1;
    @(posedge CLK); #1;

    // Directed program.
    instr(32'hE0910002, 1'b1, 3, 0);   // ADDS, fetch waits 3 cycles
    instr(32'h01510002, 1'b0, 0, 0);   // CMPEQ, condition fails
    instr(32'h01510002, 1'b1, 1, 0);   // CMPEQ, condition passes
    instr(32'hE5910004, 1'b1, 0, 2);   // LDR
    instr(32'hE5810004, 1'b1, 0, 1);   // STR
    instr(32'hEB000003, 1'b1, 0, 0);   // BL
    instr(32'hEA000003, 1'b1, 0, 0);   // B
    instr(32'hE5910004, 1'b1, 0, 14);  // LDR, MOC on the last allowed cycle
    instr(32'hE5910004, 1'b1, 0, 40);  // LDR, MOC never arrives
    instr(32'hE0910002, 1'b1, 0, 0);
    instr(32'hE5810004, 1'b1, 0, 40);  // STR, MOC never arrives
    instr(32'hE0910002, 1'b1, 40, 0);  // fetch never completes
    instr(32'hE0910002, 1'b1, 0, 0);

    // Random program.
    for (int i = 0; i < 80; i++) begin
      instr($urandom, 1'($urandom_range(0, 1)), pick_delay(), pick_delay());
    end

    while (q.size() > 0) begin
      r = q.pop_front();
      IR = r.ir; COND_OK = r.cond; MOC = r.moc;
      @(negedge CLK);
      n_assert++;
      assert (obs === r.exp) else begin
        n_fail++;
        $error("FAIL cyc%0d ir=%h observed=%h expected=%h", idx, r.ir, obs, r.exp);
      end
      idx++;
      @(posedge CLK); #1;
    end

    // Reset asserted in the middle of a fetch wait: request must drop at once.
    MOC = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #2;
    n_assert++;
    assert ({STATE, MOV} === {4'd3, 1'b1}) else begin
      n_fail++;
      $error("FAIL pre_clr_f2 observed=%h expected=%h", {STATE, MOV}, {4'd3, 1'b1});
    end
    CLR = 1'b0;
    #1;
    n_assert++;
    assert (obs === 23'd0) else begin
      n_fail++;
      $error("FAIL clr_mid_f2 observed=%h expected=%h", obs, 23'd0);
    end
    @(posedge CLK); #1;
    CLR = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
